// File: rtl/alu_interface_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: FSM state encoding and ALU opcodes.
package alu_interface_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_WAIT_TX = 3'd4
   } state_t;

   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_SRA = 8'h03;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_NOR = 8'h27;

   // A received byte has nowhere to go while a result is being produced or sent.
   function automatic logic is_busy(input state_t s);
      return (s == ST_EXEC) || (s == ST_WAIT_TX);
   endfunction

endpackage

// File: rtl/alu_interface.sv
// Collects A, B and opcode bytes from the receiver, latches the ALU result and hands it to the transmitter.
// Result appears two cycles after the opcode byte; bytes arriving while busy are dropped with an overrun pulse.
module alu_interface
   import alu_interface_pkg::*;
#(
   parameter int nb_data = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [nb_data-1:0] rx_data,
   input  logic               rx_done,
   input  logic [nb_data-1:0] alu_res,
   input  logic               tx_done,
   output logic [nb_data-1:0] dato_a,
   output logic [nb_data-1:0] dato_b,
   output logic [nb_data-1:0] op,
   output logic [nb_data-1:0] tx_data,
   output logic               tx_start,
   output logic               overrun
);

   state_t             state_q, state_d;
   logic [nb_data-1:0] dato_a_q, dato_a_d;
   logic [nb_data-1:0] dato_b_q, dato_b_d;
   logic [nb_data-1:0] op_q, op_d;
   logic [nb_data-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               overrun_q, overrun_d;

   always_comb begin
      state_d    = state_q;
      dato_a_d   = dato_a_q;
      dato_b_d   = dato_b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      overrun_d  = rx_done && is_busy(state_q);

      case (state_q)
         ST_WAIT_A: if (rx_done) begin
            dato_a_d = rx_data;
            state_d  = ST_WAIT_B;
         end
         ST_WAIT_B: if (rx_done) begin
            dato_b_d = rx_data;
            state_d  = ST_WAIT_OP;
         end
         ST_WAIT_OP: if (rx_done) begin
            op_d    = rx_data;
            state_d = ST_EXEC;
         end
         // Operands have been stable for a full cycle, so alu_res is settled here.
         ST_EXEC: begin
            tx_data_d  = alu_res;
            tx_start_d = 1'b1;
            state_d    = ST_WAIT_TX;
         end
         ST_WAIT_TX: if (tx_done) begin
            state_d = ST_WAIT_A;
         end
         default: state_d = ST_WAIT_A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_WAIT_A;
         dato_a_q   <= '0;
         dato_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dato_a_q   <= dato_a_d;
         dato_b_q   <= dato_b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overrun_q  <= overrun_d;
      end
   end

   assign dato_a   = dato_a_q;
   assign dato_b   = dato_b_q;
   assign op       = op_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign overrun  = overrun_q;

endmodule
